// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the receiver and transmitter.
// Oversampled 8N1 framing: each serial bit spans OVERSAMPLE ticks.
package uart_pkg;

   localparam logic [7:0] CLK_DIV_DEFAULT = 8'h1A;
   localparam int         OVERSAMPLE      = 16;
   localparam int         DATA_W          = 8;

   localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serialiser: load accepted only when idle (dropped while busy), txout low on the load edge.
// Every bit after the load lasts exactly OVERSAMPLE ticks; txout comes straight from a flop.
module uart_tx
   import uart_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              tick16_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              busy_o,
   output logic              txout_o
);

   tx_state_e         state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              txout_q, txout_d;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         txout_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txout_q <= txout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      txout_d = txout_q;
      case (state_q)
         TX_IDLE: begin
            txout_d = 1'b1;
            if (load_i) begin
               state_d = TX_START;
               shreg_d = data_i;
               cnt_d   = '0;
               txout_d = 1'b0;
            end
         end
         TX_START: if (tick16_i) begin
            if (cnt_q == LAST_CNT) begin
               state_d = TX_DATA;
               cnt_d   = '0;
               bit_d   = '0;
               txout_d = shreg_q[0];
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         TX_DATA: if (tick16_i) begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (bit_q == LAST_BIT) begin
                  state_d = TX_STOP;
                  txout_d = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = shreg_q >> 1;
                  txout_d = shreg_q[1];
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         TX_STOP: if (tick16_i) begin
            if (cnt_q == LAST_CNT) state_d = TX_IDLE;
            else                   cnt_d   = cnt_q + 4'd1;
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign busy_o  = (state_q != TX_IDLE);
   assign txout_o = txout_q;

endmodule

// File: rtl/uart.sv
// UART echo: oversampled 8N1 receiver with Led register, echoing each good byte via uart_tx.
// Led updates one clk after the mid-stop sample; bytes arriving while TX is busy are not echoed.
module uart
   import uart_pkg::*;
#(
   parameter logic [7:0] CLK_DIV = CLK_DIV_DEFAULT
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rxin,
   output logic       txout,
   output logic [7:0] Led
);

   localparam logic [8:0] TICK_LAST = 9'(2 * (int'(CLK_DIV) + 1) - 1);

   logic [8:0]        tick_q;
   logic              tick16;
   logic              rx_meta_q, rx_sync_q;
   rx_state_e         rx_state_q, rx_state_d;
   logic [3:0]        rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic              ferr_q, ferr_d;
   logic [DATA_W-1:0] led_q, led_d;
   logic              rx_done_q, rx_done_d;
   logic              tx_busy;

   assign tick16 = (tick_q == TICK_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_q     <= '0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         ferr_q     <= 1'b0;
         led_q      <= '0;
         rx_done_q  <= 1'b0;
      end else begin
         tick_q     <= tick16 ? 9'd0 : tick_q + 9'd1;
         rx_meta_q  <= rxin;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         ferr_q     <= ferr_d;
         led_q      <= led_d;
         rx_done_q  <= rx_done_d;
      end
   end

   // Start is qualified at mid-bit; data and stop are then sampled every OVERSAMPLE ticks.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      ferr_d     = ferr_q;
      led_d      = led_q;
      rx_done_d  = 1'b0;
      if (tick16) begin
         case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
            RX_START: begin
               if (rx_cnt_q == MID_CNT) begin
                  rx_cnt_d = '0;
                  rx_bit_d = '0;
                  rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + 4'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == LAST_CNT) begin
                  rx_cnt_d   = '0;
                  rx_bit_d   = rx_bit_q + 3'd1;
                  rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                  if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
               end else begin
                  rx_cnt_d = rx_cnt_q + 4'd1;
               end
            end
            RX_STOP: begin
               if (ferr_q) begin
                  if (rx_sync_q) begin
                     rx_state_d = RX_IDLE;
                     ferr_d     = 1'b0;
                  end
               end else if (rx_cnt_q == LAST_CNT) begin
                  if (rx_sync_q) begin
                     led_d      = rx_shift_q;
                     rx_done_d  = 1'b1;
                     rx_state_d = RX_IDLE;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + 4'd1;
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   uart_tx u_tx (
      .clk_i    (clk),
      .reset_ni (reset),
      .tick16_i (tick16),
      .load_i   (rx_done_q && !tx_busy),
      .data_i   (led_q),
      .busy_o   (tx_busy),
      .txout_o  (txout)
   );

   assign Led = led_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART echo: drives serial frames, scoreboards Led updates and echoed TX frames.
module tb_uart;

   localparam int BIT_CLK = 864;
   localparam int TPER    = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxin;
   logic       txout;
   logic [7:0] Led;

   int  vectors     = 0;
   int  miscompares = 0;
   int  tx_frames   = 0;
   logic [7:0] exp_led[$];
   logic [7:0] exp_tx[$];
   time last_start = 0;
   time led_time   = 0;
   bit  led_mon_en = 1'b1;
   bit  tx_mon_en  = 1'b1;

   uart dut (
      .clk   (clk),
      .reset (reset),
      .rxin  (rxin),
      .txout (txout),
      .Led   (Led)
   );

   always #(TPER/2) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_b);
      rxin = 1'b0;
      last_start = $time;
      clks(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rxin = b[i];
         clks(BIT_CLK);
      end
      rxin = stop_b;
      clks(BIT_CLK);
      rxin = 1'b1;
   endtask

   // Led monitor: each change must match the next expected byte, 9..9.6 bit times after the start edge.
   initial begin
      logic [7:0] led_prev;
      time        dt;
      led_prev = 8'h00;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && led_mon_en && Led !== led_prev) begin
            dt = $time - last_start;
            led_time = $time;
            vectors++;
            assert (exp_led.size() > 0) else begin
               miscompares++;
               $error("FAIL led_unexpected: observed %0h expected no change", Led);
            end
            if (exp_led.size() > 0) check("led_value", 32'(Led), 32'(exp_led.pop_front()));
            check("led_latency", 32'(dt >= 9 * BIT_CLK * TPER && dt <= (96 * BIT_CLK * TPER) / 10), 1);
         end
         led_prev = Led;
      end
   end

   // TX monitor: decode at mid-bit from the falling start edge and compare against the echo queue.
   initial begin
      logic       prev_tx;
      logic [7:0] b;
      time        t0;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_mon_en && reset === 1'b1 && prev_tx === 1'b1 && txout === 1'b0) begin
            t0 = $time;
            check("tx_start_latency", 32'((t0 - led_time) <= 2 * 54 * TPER), 1);
            repeat (BIT_CLK / 2) @(negedge clk);
            check("tx_start_bit", 32'(txout), 0);
            for (int k = 0; k < 8; k++) begin
               repeat (BIT_CLK) @(negedge clk);
               b[k] = txout;
            end
            repeat (BIT_CLK) @(negedge clk);
            check("tx_stop_bit", 32'(txout), 1);
            tx_frames++;
            vectors++;
            assert (exp_tx.size() > 0) else begin
               miscompares++;
               $error("FAIL tx_unexpected: observed frame %0h expected none", b);
            end
            if (exp_tx.size() > 0) check("tx_echo", 32'(b), 32'(exp_tx.pop_front()));
         end
         prev_tx = txout;
      end
   end

   initial begin
      reset = 1'b0;
      rxin  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset_led", 32'(Led), 0);
         check("reset_txout", 32'(txout), 1);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      clks(8);
      check("led_before_rx", 32'(Led), 0);

      // Good frame 0x39, echoed.
      exp_led.push_back(8'h39);
      exp_tx.push_back(8'h39);
      send_frame(8'h39, 1'b1);
      clks(11 * BIT_CLK);
      check("led_39", 32'(Led), 32'h39);
      check("frames_after_39", tx_frames, 1);

      // Framing error: byte discarded, nothing echoed.
      send_frame(8'hA5, 1'b0);
      clks(2 * BIT_CLK);
      check("led_after_ferr", 32'(Led), 32'h39);
      check("frames_after_ferr", tx_frames, 1);

      // Short low glitch is a false start.
      rxin = 1'b0;
      clks(300);
      rxin = 1'b1;
      clks(2 * BIT_CLK);
      check("led_after_glitch", 32'(Led), 32'h39);
      check("txout_after_glitch", 32'(txout), 1);
      check("frames_after_glitch", tx_frames, 1);

      // Back-to-back frames, both echoed in order.
      exp_led.push_back(8'h55);
      exp_tx.push_back(8'h55);
      exp_led.push_back(8'hAA);
      exp_tx.push_back(8'hAA);
      send_frame(8'h55, 1'b1);
      send_frame(8'hAA, 1'b1);
      clks(11 * BIT_CLK);
      check("led_aa", 32'(Led), 32'hAA);
      check("frames_after_b2b", tx_frames, 3);
      check("led_queue_empty", exp_led.size(), 0);
      check("tx_queue_empty", exp_tx.size(), 0);

      // Reset mid-frame on both RX and TX.
      led_mon_en = 1'b0;
      tx_mon_en  = 1'b0;
      send_frame(8'h3C, 1'b1);
      rxin = 1'b0;
      clks(3 * BIT_CLK);
      reset = 1'b0;
      clks(1);
      check("midreset_txout", 32'(txout), 1);
      check("midreset_led", 32'(Led), 0);
      reset = 1'b1;
      rxin  = 1'b1;
      clks(2 * BIT_CLK);
      check("post_reset_txout", 32'(txout), 1);
      check("post_reset_led", 32'(Led), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
